dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: W0, default 3, max consecutive contested grants to port 0 before port 1 wins one (legal 1..15).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 m0_req  input  1  port 0 (CPU data side) access request; held with its fields until the handshake.
REQ-005 m0_we  input  1  port 0 write enable (1 = write, 0 = read).
REQ-006 m0_addr  input  32  port 0 byte address.
REQ-007 m0_wdata  input  32  port 0 write data.
REQ-008 m0_gnt  output  1  port 0 grant; a transfer occurs at the rising edge where m0_req and m0_gnt are both 1.
REQ-009 m0_rvalid  output  1  port 0 read data valid on m_rdata.
REQ-010 m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid: port 1 (DMA/debug), same directions, widths and meanings as port 0.
REQ-011 m_rdata  output  32  read data broadcast to both ports, equal to mem_rdata.
REQ-012 mem_en  output  1  memory access strobe, registered.
REQ-013 mem_we  output  1  memory write enable, registered.
REQ-014 mem_addr  output  32  memory address, registered.
REQ-015 mem_wdata  output  32  memory write data, registered.
REQ-016 mem_rdata  input  32  memory read data, valid the cycle after a mem_en=1, mem_we=0 cycle.

Function
REQ-017 Grants are combinational from the req inputs and the registered contest counter cnt (4 bits).
REQ-018 Only m0_req=1: m0_gnt=1 and cnt is unchanged.
REQ-019 Only m1_req=1: m1_gnt=1 and cnt becomes 0.
REQ-020 Both requests with cnt<W0: m0_gnt=1, m1_gnt=0 and cnt increments.
REQ-021 Both requests with cnt>=W0: m1_gnt=1, m0_gnt=0 and cnt becomes 0.
REQ-022 m0_gnt and m1_gnt are never both 1, and neither is 1 without its req.
REQ-023 At most one transfer per cycle; back-to-back transfers every cycle are supported with no bubble.
REQ-024 On a handshake edge, mem_en becomes 1 and mem_we, mem_addr and mem_wdata take the winning port's fields.
REQ-025 On an edge with no handshake, mem_en and mem_we become 0, and mem_addr and mem_wdata hold their values.
REQ-026 A read handshake registers a 1-bit port tag; the matching mX_rvalid is 1 for exactly one cycle, the cycle after the mem_en cycle (two edges after the handshake).
REQ-027 Write handshakes never raise any rvalid.
REQ-028 m0_rvalid and m1_rvalid are never both 1; reads complete in issue order.
REQ-029 m_rdata = mem_rdata at all times; its value is meaningful only while an rvalid is 1.
REQ-030 Request fields are sampled only at the handshake edge; changes while ungranted are ignored.

Reset
REQ-031 While rst=0: mem_en, mem_we, mem_addr, mem_wdata, m0_rvalid, m1_rvalid, cnt and the tag pipeline are all 0, and both grants are forced to 0.
REQ-032 Reset asserted mid-operation discards in-flight reads; no rvalid is produced for them after release.
REQ-033 On the first edge after release, normal arbitration applies with cnt=0.

Verification
REQ-034 Port 0 read addr 0x10, mem_rdata=0xDEADBEEF -> m0_gnt same cycle; next cycle mem_en=1, mem_we=0, addr 0x10; following cycle m0_rvalid=1, m_rdata=0xDEADBEEF, m1_rvalid=0.
REQ-035 Both ports issue reads held continuously, W0=3 -> grant sequence 0,0,0,1,0,0,0,1; rvalid per port follows two edges after each of its grants.
REQ-036 Port 1 only, write addr 0x200 data 0x12345678 -> m1_gnt=1 immediately; next cycle mem_en=1, mem_we=1 with those values; no rvalid; cnt=0.
REQ-037 Alternating single-cycle reads port0/port1/port0 on consecutive cycles -> mem_en high 3 cycles; rvalid sequence m0, m1, m0 on consecutive cycles, each with the matching data.
REQ-038 rst pulled low for one cycle between a read handshake and its rvalid -> no rvalid, all outputs 0; after release, both requests -> port 0 granted (cnt=0).
REQ-039 W0=1, both ports requesting continuously -> strict alternation 0,1,0,1.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundles both requester ports and the memory-side bus of the data-memory arbiter.
// slave = arbiter view; master = requesters plus memory (the surrounding system).
interface dmem_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_rvalid;

    logic        m1_req;
    logic        m1_we;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;

    logic [31:0] m_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid,
        output m_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid,
        input  m_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter, port 0 wins up to W0 contested grants in a row, then port 1.
// Grant is combinational; memory strobe 1 edge later, rvalid 2 edges later; requesters stall by holding req until gnt.
module dmem_arbiter #(
    parameter int unsigned W0 = 3
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    logic [3:0]  cnt;
    logic        both_req;
    logic        pick1;
    logic        gnt0;
    logic        gnt1;
    logic        hs0;
    logic        hs1;

    logic        mem_en_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        rd_vld_q;
    logic        rd_tag_q;
    logic        m0_rvalid_q;
    logic        m1_rvalid_q;

    // Port 1 wins a contest only once port 0 has used its run of W0 grants.
    assign both_req = bus.m0_req && bus.m1_req;
    assign pick1    = both_req && (cnt >= 4'(W0));
    assign gnt0     = rst && bus.m0_req && !pick1;
    assign gnt1     = rst && bus.m1_req && (!bus.m0_req || pick1);
    assign hs0      = bus.m0_req && gnt0;
    assign hs1      = bus.m1_req && gnt1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rd_vld_q    <= 1'b0;
            rd_tag_q    <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
        end else begin
            if (hs1)
                cnt <= 4'd0;
            else if (hs0 && both_req)
                cnt <= cnt + 4'd1;

            if (hs0) begin
                mem_en_q    <= 1'b1;
                mem_we_q    <= bus.m0_we;
                mem_addr_q  <= bus.m0_addr;
                mem_wdata_q <= bus.m0_wdata;
            end else if (hs1) begin
                mem_en_q    <= 1'b1;
                mem_we_q    <= bus.m1_we;
                mem_addr_q  <= bus.m1_addr;
                mem_wdata_q <= bus.m1_wdata;
            end else begin
                mem_en_q    <= 1'b0;
                mem_we_q    <= 1'b0;
            end

            // Tag travels alongside the memory access so the response returns to its issuer.
            rd_vld_q    <= (hs0 && !bus.m0_we) || (hs1 && !bus.m1_we);
            rd_tag_q    <= hs1;
            m0_rvalid_q <= rd_vld_q && !rd_tag_q;
            m1_rvalid_q <= rd_vld_q && rd_tag_q;
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_rvalid = m0_rvalid_q;
    assign bus.m1_rvalid = m1_rvalid_q;
    assign bus.m_rdata   = bus.mem_rdata;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle grant/memory-bus checks plus a read-response scoreboard.
module tb_dmem_arbiter;

    typedef struct {
        logic        tag;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    int   n_assert = 0;
    int   n_fail   = 0;
    string phase = "reset";

    exp_t sb[$];

    // Expected memory-bus state produced by the previous cycle's handshake.
    logic        x_en    = 1'b0;
    logic        x_we    = 1'b0;
    logic [31:0] x_addr  = 32'd0;
    logic [31:0] x_wdata = 32'd0;

    dmem_arbiter_if bus ();
    dmem_arbiter_if bus1 ();

    dmem_arbiter #(.W0(3)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    dmem_arbiter #(.W0(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'h10)
            return 32'hDEADBEEF;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Memory model: read data appears the cycle after a read strobe.
    always @(posedge clk) begin
        if (bus.mem_en && !bus.mem_we)
            bus.mem_rdata <= mem_val(bus.mem_addr);
        else
            bus.mem_rdata <= 32'h0;
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0h expected %0h", phase, name, obs, exp);
        end
    endtask

    task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                        input logic g0, input logic g1);
        exp_t e;
        logic ev0, ev1;
        logic [31:0] ed;
        @(negedge clk);
        bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req = r1; bus.m1_we = w1; bus.m1_addr = a1; bus.m1_wdata = d1;
        #1;
        chk("m0_gnt", bus.m0_gnt, g0);
        chk("m1_gnt", bus.m1_gnt, g1);
        chk("mem_en", bus.mem_en, x_en);
        chk("mem_we", bus.mem_we, x_we);
        chk("mem_addr", bus.mem_addr, x_addr);
        chk("mem_wdata", bus.mem_wdata, x_wdata);

        ev0 = 1'b0; ev1 = 1'b0; ed = 32'h0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            if (e.tag) ev1 = 1'b1; else ev0 = 1'b1;
            ed = e.data;
        end
        chk("m0_rvalid", bus.m0_rvalid, ev0);
        chk("m1_rvalid", bus.m1_rvalid, ev1);
        if (ev0 || ev1)
            chk("m_rdata", bus.m_rdata, ed);

        if (r0 && g0) begin
            x_en = 1'b1; x_we = w0; x_addr = a0; x_wdata = d0;
            if (!w0) sb.push_back('{tag: 1'b0, data: mem_val(a0), due: cyc + 2});
        end else if (r1 && g1) begin
            x_en = 1'b1; x_we = w1; x_addr = a1; x_wdata = d1;
            if (!w1) sb.push_back('{tag: 1'b1, data: mem_val(a1), due: cyc + 2});
        end else begin
            x_en = 1'b0; x_we = 1'b0;
        end
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_m0_gnt", bus.m0_gnt, 1'b0);
        chk("rst_m1_gnt", bus.m1_gnt, 1'b0);
        chk("rst_mem_en", bus.mem_en, 1'b0);
        chk("rst_mem_we", bus.mem_we, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_m0_rvalid", bus.m0_rvalid, 1'b0);
        chk("rst_m1_rvalid", bus.m1_rvalid, 1'b0);
    endtask

    initial begin
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
        bus1.m0_req = 0; bus1.m0_we = 0; bus1.m0_addr = 0; bus1.m0_wdata = 0;
        bus1.m1_req = 0; bus1.m1_we = 0; bus1.m1_addr = 0; bus1.m1_wdata = 0;
        bus1.mem_rdata = 32'h0;

        // Reset state, with both requests raised to prove grants are forced low.
        @(negedge clk);
        bus.m0_req = 1; bus.m1_req = 1;
        #1;
        chk_reset_outputs();
        @(negedge clk);
        bus.m0_req = 0; bus.m1_req = 0;
        rst = 1'b1;

        phase = "p0_read";
        step(1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0);
        idle();
        idle();
        idle();

        phase = "p1_write";
        step(0, 0, 32'h0, 32'h0, 1, 1, 32'h200, 32'h12345678, 0, 1);
        idle();
        idle();
        idle();

        // m1 fields change while it waits; only the granted cycle's values may reach memory.
        phase = "contest_w3";
        for (int i = 0; i < 8; i++)
            step(1, 0, 32'h100 + 32'(i * 4), 32'h0, 1, 0, 32'h300 + 32'(i * 4), 32'h0,
                 (i % 4) != 3, (i % 4) == 3);
        idle();
        idle();
        idle();

        phase = "alternate";
        step(1, 0, 32'h20, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0);
        step(0, 0, 32'h0, 32'h0, 1, 0, 32'h24, 32'h0, 0, 1);
        step(1, 0, 32'h28, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0);
        idle();
        idle();
        idle();

        // Build cnt up to 2, then reset between a read handshake and its response.
        phase = "mid_reset";
        step(1, 0, 32'h30, 32'h0, 1, 1, 32'h34, 32'h55, 1, 0);
        step(1, 0, 32'h38, 32'h0, 1, 1, 32'h34, 32'h55, 1, 0);
        step(1, 0, 32'h40, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0);
        @(negedge clk);
        bus.m0_req = 1; bus.m1_req = 1;
        rst = 1'b0;
        #1;
        chk_reset_outputs();
        sb.delete();
        x_en = 1'b0; x_we = 1'b0; x_addr = 32'h0; x_wdata = 32'h0;
        @(negedge clk);
        #1;
        chk_reset_outputs();
        bus.m0_req = 0; bus.m1_req = 0;
        rst = 1'b1;

        phase = "after_reset";
        idle();
        idle();
        step(1, 0, 32'h50, 32'h0, 1, 0, 32'h60, 32'h0, 1, 0);
        step(1, 0, 32'h50, 32'h0, 1, 0, 32'h60, 32'h0, 1, 0);
        step(1, 0, 32'h50, 32'h0, 1, 0, 32'h60, 32'h0, 1, 0);
        step(1, 0, 32'h50, 32'h0, 1, 0, 32'h60, 32'h0, 0, 1);
        idle();
        idle();
        idle();

        phase = "contest_w1";
        @(negedge clk);
        bus1.m0_req = 1; bus1.m1_req = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("w1_m0_gnt", bus1.m0_gnt, (i % 2) == 0);
            chk("w1_m1_gnt", bus1.m1_gnt, (i % 2) == 1);
            @(negedge clk);
        end
        bus1.m0_req = 0; bus1.m1_req = 0;

        phase = "drain";
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
